// File: rtl/jlsemi_util_reset_release_seq.sv
// Staged reset-release sequencer: holds N_OUT active-low resets low for ASSERT_CYC
// cycles, then releases them one by one (bit 0 first) every GAP_CYC cycles.
module jlsemi_util_reset_release_seq #(
   parameter int N_OUT      = 4,
   parameter int ASSERT_CYC = 16,
   parameter int GAP_CYC    = 8,
   parameter int CNT_W      = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             sw_rst_req_i,
   input  logic             dft_rstnsync_scan_rstn_ctrl,
   input  logic             dft_rstnsync_scan_rstn,
   output logic [N_OUT-1:0] rst_n_o,
   output logic             rst_busy_o,
   output logic             rst_done_o
);

   localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RELEASE = 2'd1,
      ST_DONE    = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [N_OUT-1:0] rst_n_q, rst_n_d;
   logic             req_q;
   logic             req_edge;
   logic             rst_n_pre;

   // In scan mode the flops take their reset from the scan reset pin.
   assign rst_n_pre = dft_rstnsync_scan_rstn_ctrl ? dft_rstnsync_scan_rstn : rst_n_i;
   assign req_edge  = sw_rst_req_i & ~req_q;

   always_ff @(posedge clk_i or negedge rst_n_pre) begin
      if (!rst_n_pre) begin
         state_q <= ST_ASSERT;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_n_q <= '0;
         req_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rst_n_q <= rst_n_d;
         req_q   <= sw_rst_req_i;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rst_n_d = rst_n_q;
      if (req_edge) begin
         // A request edge wins over any release due at the same edge.
         state_d = ST_ASSERT;
         cnt_d   = '0;
         idx_d   = '0;
         rst_n_d = '0;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               if (cnt_q == CNT_W'(ASSERT_CYC - 1)) begin
                  rst_n_d[0] = 1'b1;
                  cnt_d      = '0;
                  idx_d      = IDX_W'(1);
                  state_d    = (N_OUT == 1) ? ST_DONE : ST_RELEASE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_RELEASE: begin
               if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                  for (int unsigned i = 0; i < N_OUT; i++) begin
                     if (idx_q == IDX_W'(i)) rst_n_d[i] = 1'b1;
                  end
                  cnt_d = '0;
                  if (idx_q == IDX_W'(N_OUT - 1)) begin
                     state_d = ST_DONE;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_ASSERT;
               cnt_d   = '0;
               idx_d   = '0;
               rst_n_d = '0;
            end
         endcase
      end
   end

   always_comb begin
      rst_done_o = (state_q == ST_DONE);
      rst_busy_o = (state_q != ST_DONE);
      rst_n_o    = dft_rstnsync_scan_rstn_ctrl ? {N_OUT{dft_rstnsync_scan_rstn}} : rst_n_q;
   end

endmodule

// File: doc/jlsemi_util_reset_release_seq.md
Name: jlsemi_util_reset_release_seq

Overview:
- Reset-domain sequencer that sits downstream of an async-assert/sync-deassert reset synchroniser on clk_i.
- Drives N_OUT active-low reset outputs: all held asserted for a minimum pulse, then released one at a time with a fixed gap (output 0 first).
- Supports a synchronous software re-reset request and the standard DFT scan-reset bypass.
- Used to stage release of datapath sub-blocks, e.g. ADC capture front end before buffer before CSR logic.

Parameters:
- N_OUT, 4: number of reset outputs; legal range >=1.
- ASSERT_CYC, 16: clk_i cycles all outputs stay low before output 0 releases; legal range >=1.
- GAP_CYC, 8: clk_i cycles between successive output releases; legal range >=1.
- CNT_W, 8: counter width; must satisfy 2^CNT_W > max(ASSERT_CYC, GAP_CYC).

Ports:
- clk_i  input  1  block clock.
- rst_n_i  input  1  asynchronous active-low reset (already synchronised to clk_i upstream).
- sw_rst_req_i  input  1  software reset request, synchronous to clk_i; a rising edge triggers a full re-sequence.
- dft_rstnsync_scan_rstn_ctrl  input  1  scan mode select; 1 = bypass.
- dft_rstnsync_scan_rstn  input  1  scan reset value used in bypass.
- rst_n_o  output  N_OUT  staged active-low resets; bit i releases i-th.
- rst_busy_o  output  1  1 while any rst_n_o bit is low (functional path).
- rst_done_o  output  1  1 once all outputs are released.

Behaviour:
- Reset and clocking: one clock, clk_i. Reset is asynchronous, active-low. The internal flop reset is rst_n_pre = ctrl ? dft_rstnsync_scan_rstn : rst_n_i.
- Reset values:
  - state = ST_ASSERT, cnt = 0, idx = 0.
  - rst_n_o = all 0, rst_busy_o = 1, rst_done_o = 0.
  - Request-edge register req_d = 1, so a request held high through reset does not re-trigger.
- Edge numbering: edge 1 is the first clk_i rising edge after rst_n_pre deasserts.
- ST_ASSERT:
  - cnt increments each edge.
  - At the edge where cnt==ASSERT_CYC-1: set rst_n_o[0]=1, cnt=0, idx=1.
  - If N_OUT==1, go to ST_DONE; otherwise go to ST_RELEASE.
- ST_RELEASE:
  - cnt increments each edge.
  - At the edge where cnt==GAP_CYC-1: set rst_n_o[idx]=1, cnt=0, idx++.
  - If idx was N_OUT-1, go to ST_DONE.
- Release timing: output i rises at edge ASSERT_CYC + i*GAP_CYC. Defaults give 16, 24, 32, 40.
- ST_DONE:
  - rst_done_o=1, rst_busy_o=0, and both update at the same edge as the last release.
  - Holds until a request or reset.
- Software request:
  - req_edge = sw_rst_req_i & ~req_d. req_d is registered every edge.
  - On a sampled req_edge, in any state: at that edge all rst_n_o go 0, busy=1, done=0, cnt=0, idx=0, state=ST_ASSERT.
  - req_edge has priority over any release scheduled at the same edge; that release does not occur.
  - Releases then follow the same schedule, relative to the request edge k: output i rises at k + ASSERT_CYC + i*GAP_CYC.
  - Holding the request high does not extend assertion; only rising edges count.
- Async reset mid-sequence: immediately returns every output and state to its reset values; the sequence restarts from edge 1.
- Output bits are registered directly (no combinational decode) so they are glitch-free. Once released, a bit stays 1 until a reset or request.
- DFT bypass:
  - rst_n_o = ctrl ? {N_OUT{dft_rstnsync_scan_rstn}} : rst_n_reg.
  - This path is combinational and also applies during async reset.
  - rst_busy_o and rst_done_o are not bypassed.
- Counter width: it never exceeds max(ASSERT_CYC, GAP_CYC)-1, so there is no wrap.

Test Plan:
1. Defaults, rst_n_i released, sw_rst_req_i=0, ctrl=0 -> rst_n_o bits 0..3 rise at edges 16/24/32/40. rst_done_o=1 and rst_busy_o=0 at edge 40. No bit rises early.
2. ST_DONE reached, sw_rst_req_i pulsed for 1 cycle, sampled at edge k -> rst_n_o=4'b0000 after edge k. Bits rise again at k+16/k+24/k+32/k+40. Holding the request high for 100 cycles yields the same result.
3. Request sampled at edge 24 (coincident with bit 1's scheduled release) -> bit 1 does not rise, outputs become 0000, and bit 0 next rises at edge 40.
4. rst_n_i asserted low at edge 28 (bits 0,1 high) -> rst_n_o=0000, busy=1, done=0 immediately and asynchronously. On release, the schedule restarts at edge 16.
5. ctrl=1, scan_rstn toggled 0/1 with rst_n_i low -> every rst_n_o bit follows scan_rstn combinationally. With ctrl=0 and scan_rstn=0 the functional sequence is unaffected.
6. N_OUT=1, ASSERT_CYC=1, GAP_CYC=1 -> rst_n_o[0] rises at edge 1 and rst_done_o=1 at edge 1.
